// File: rtl/access_controller.sv
// Access controller: edge-triggered request, one-cycle permission check, timed grant/deny
// indication, and an optional lockout after repeated denials (enabled by ACCESS_LOCKOUT_EN).
module access_controller #(
   parameter int HOLD_CYCLES = 8,
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] user,
   input  logic [2:0] func,
   input  logic       request,
   input  logic       valid_bit,
   output logic [2:0] user_sel,
   output logic [2:0] func_sel,
   output logic       granted,
   output logic       denied,
   output logic       locked,
   output logic       busy,
   output logic [1:0] fail_count,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_GRANT = 3'd2,
      S_DENY  = 3'd3
`ifdef ACCESS_LOCKOUT_EN
      , S_LOCKED = 3'd4
`endif
   } state_t;

   // Counter is loaded with N-1 on entry so a state lasts exactly N cycles.
   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
`ifdef ACCESS_LOCKOUT_EN
   localparam logic [7:0] LOCK_LOAD = 8'(LOCK_CYCLES - 1);
   localparam logic [1:0] FAIL_SAT  = 2'(MAX_FAILS);
`else
   localparam logic [1:0] FAIL_SAT  = 2'd3;
`endif

   state_t     state;
   logic [7:0] cnt;
   logic       req_q;
   logic       req_armed;
   logic       req_edge;
   logic [1:0] fail_inc;

   // req_armed blocks a request held high across reset release until it has been seen low.
   assign req_edge  = request & ~req_q & req_armed;
   assign fail_inc  = (fail_count == FAIL_SAT) ? fail_count : fail_count + 2'd1;
   assign state_dbg = state;

`ifndef ACCESS_LOCKOUT_EN
   assign locked = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= 8'd0;
         req_q      <= 1'b0;
         req_armed  <= 1'b0;
         user_sel   <= 3'd0;
         func_sel   <= 3'd0;
         fail_count <= 2'd0;
         granted    <= 1'b0;
         denied     <= 1'b0;
         busy       <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
         locked     <= 1'b0;
`endif
      end else begin
         req_q     <= request;
         req_armed <= req_armed | ~request;
         case (state)
            S_IDLE: begin
               if (req_edge) begin
                  user_sel <= user;
                  func_sel <= func;
                  busy     <= 1'b1;
                  state    <= S_CHECK;
               end
            end
            S_CHECK: begin
               cnt <= HOLD_LOAD;
               if (valid_bit) begin
                  granted    <= 1'b1;
                  fail_count <= 2'd0;
                  state      <= S_GRANT;
               end else begin
                  denied     <= 1'b1;
                  fail_count <= fail_inc;
                  state      <= S_DENY;
               end
            end
            S_GRANT: begin
               if (cnt == 8'd0) begin
                  granted <= 1'b0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            S_DENY: begin
               if (cnt == 8'd0) begin
                  denied <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
                  if (fail_count == FAIL_SAT) begin
                     locked <= 1'b1;
                     cnt    <= LOCK_LOAD;
                     state  <= S_LOCKED;
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
`else
                  busy  <= 1'b0;
                  state <= S_IDLE;
`endif
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
`ifdef ACCESS_LOCKOUT_EN
            S_LOCKED: begin
               if (cnt == 8'd0) begin
                  locked     <= 1'b0;
                  busy       <= 1'b0;
                  fail_count <= 2'd0;
                  state      <= S_IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
`endif
            default: begin
               granted <= 1'b0;
               denied  <= 1'b0;
               busy    <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
               locked  <= 1'b0;
`endif
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_access_controller.sv
// Bench for access_controller: directed scenarios plus random transactions checked against
// a transaction-level model of fail counting, hold/lock durations and output flags.
module tb_access_controller;

   localparam int HOLD_CYCLES = 8;
   localparam int MAX_FAILS   = 3;
   localparam int LOCK_CYCLES = 16;
`ifdef ACCESS_LOCKOUT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif
   localparam int FAIL_SAT = LOCK_EN ? MAX_FAILS : 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] user = 3'd0;
   logic [2:0] func = 3'd0;
   logic       request = 1'b0;
   logic       valid_bit = 1'b0;
   logic [2:0] user_sel;
   logic [2:0] func_sel;
   logic       granted;
   logic       denied;
   logic       locked;
   logic       busy;
   logic [1:0] fail_count;
   logic [2:0] state_dbg;

   int total = 0;
   int bad = 0;
   int exp_fails = 0;

   access_controller #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .MAX_FAILS  (MAX_FAILS),
      .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .user      (user),
      .func      (func),
      .request   (request),
      .valid_bit (valid_bit),
      .user_sel  (user_sel),
      .func_sel  (func_sel),
      .granted   (granted),
      .denied    (denied),
      .locked    (locked),
      .busy      (busy),
      .fail_count(fail_count),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Asserts reset for one edge at the current negedge and checks the cleared outputs.
   task automatic apply_reset_check(input string tag);
      reset   = 1'b1;
      request = 1'b0;
      @(negedge clk);
      total++;
      if ({granted, denied, locked, busy, fail_count, user_sel, func_sel} !== 12'd0) begin
         bad++;
         $display("FAIL %s reset_clear: got g=%b d=%b l=%b b=%b fc=%0d us=%0d fs=%0d want all 0 (state=%0d)",
                  tag, granted, denied, locked, busy, fail_count, user_sel, func_sel, state_dbg);
      end
      reset     = 1'b0;
      exp_fails = 0;
      @(negedge clk);
   endtask

   // One full transaction from request edge back to idle, checked cycle by cycle.
   // reset_at>0 asserts reset in that cycle (1-based) of the grant/deny/lock phase.
   task automatic do_request(input logic [2:0] u, input logic [2:0] f, input logic v,
                             input bit poke, input int reset_at, input int gap);
      logic [1:0] of, nf;
      logic       lock;
      int         n;
      of   = 2'(exp_fails);
      nf   = v ? 2'd0 : ((exp_fails == FAIL_SAT) ? of : of + 2'd1);
      lock = LOCK_EN && !v && (int'(nf) == MAX_FAILS);
      n    = 0;

      user = u; func = f; valid_bit = v; request = 1'b1;
      @(negedge clk);
      total++;
      if ({granted, denied, locked, busy} !== 4'b0001) begin
         bad++;
         $display("FAIL check_flags: got gdlb=%b want 0001 (state=%0d)", {granted, denied, locked, busy}, state_dbg);
      end
      total++;
      if ({user_sel, func_sel, fail_count} !== {u, f, of}) begin
         bad++;
         $display("FAIL check_latch: got us=%0d fs=%0d fc=%0d want us=%0d fs=%0d fc=%0d",
                  user_sel, func_sel, fail_count, u, f, of);
      end
      user = 3'($urandom); func = 3'($urandom);
      if (poke) request = 1'($urandom_range(0, 1));
      @(negedge clk);
      valid_bit = 1'($urandom_range(0, 1));

      for (int i = 0; i < HOLD_CYCLES; i++) begin
         n++;
         total++;
         if ({granted, denied, locked, busy} !== {v, ~v, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL hold_flags cyc%0d: got gdlb=%b want %b (state=%0d)", n,
                     {granted, denied, locked, busy}, {v, ~v, 1'b0, 1'b1}, state_dbg);
         end
         total++;
         if ({user_sel, func_sel, fail_count} !== {u, f, nf}) begin
            bad++;
            $display("FAIL hold_data cyc%0d: got us=%0d fs=%0d fc=%0d want us=%0d fs=%0d fc=%0d",
                     n, user_sel, func_sel, fail_count, u, f, nf);
         end
         if (reset_at == n) begin
            apply_reset_check("mid_hold");
            repeat (gap) @(negedge clk);
            return;
         end
         if (poke) request = 1'($urandom_range(0, 1));
         @(negedge clk);
      end

      if (lock) begin
         for (int i = 0; i < LOCK_CYCLES; i++) begin
            n++;
            total++;
            if ({granted, denied, locked, busy, fail_count} !== {4'b0011, nf}) begin
               bad++;
               $display("FAIL lock_flags cyc%0d: got gdlb=%b fc=%0d want gdlb=0011 fc=%0d (state=%0d)",
                        n, {granted, denied, locked, busy}, fail_count, nf, state_dbg);
            end
            if (reset_at == n) begin
               apply_reset_check("mid_lock");
               repeat (gap) @(negedge clk);
               return;
            end
            if (poke) request = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         nf = 2'd0;
      end

      exp_fails = int'(nf);
      total++;
      if ({granted, denied, locked, busy, fail_count} !== {4'b0000, nf}) begin
         bad++;
         $display("FAIL idle_return: got gdlb=%b fc=%0d want gdlb=0000 fc=%0d (state=%0d)",
                  {granted, denied, locked, busy}, fail_count, nf, state_dbg);
      end
      request = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({granted, denied, locked, busy, fail_count, user_sel, func_sel} !== 12'd0) begin
         bad++;
         $display("FAIL reset_state: got g=%b d=%b l=%b b=%b fc=%0d us=%0d fs=%0d want all 0",
                  granted, denied, locked, busy, fail_count, user_sel, func_sel);
      end
      reset = 1'b0;
      exp_fails = 0;
      @(negedge clk);
   endtask

   task automatic test_grant();
      do_request(3'b101, 3'b010, 1'b1, 1'b0, 0, 1);
   endtask

   task automatic test_lockout();
      for (int i = 0; i < 4; i++) do_request(3'($urandom), 3'($urandom), 1'b0, 1'b0, 0, 2);
   endtask

   task automatic test_recovery();
      apply_reset_check("recovery_pre");
      do_request(3'd1, 3'd1, 1'b0, 1'b0, 0, 1);
      do_request(3'd2, 3'd2, 1'b0, 1'b0, 0, 1);
      do_request(3'd3, 3'd3, 1'b1, 1'b0, 0, 1);
      do_request(3'd4, 3'd4, 1'b0, 1'b0, 0, 1);
   endtask

   task automatic test_ignored();
      do_request(3'd6, 3'd5, 1'b1, 1'b1, 0, 1);
      reset   = 1'b1;
      request = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_fails = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || user_sel !== 3'd0) begin
            bad++;
            $display("FAIL held_request: got busy=%b us=%0d want busy=0 us=0 (state=%0d)", busy, user_sel, state_dbg);
         end
      end
      request = 1'b0;
      @(negedge clk);
      do_request(3'd7, 3'd7, 1'b1, 1'b0, 0, 1);
   endtask

   task automatic test_mid_reset();
      do_request(3'd2, 3'd3, 1'b1, 1'b0, 3, 1);
      do_request(3'd4, 3'd1, 1'b0, 1'b0, 5, 1);
`ifdef ACCESS_LOCKOUT_EN
      apply_reset_check("mid_pre");
      for (int i = 0; i < MAX_FAILS - 1; i++) do_request(3'd1, 3'd2, 1'b0, 1'b0, 0, 1);
      do_request(3'd1, 3'd2, 1'b0, 1'b0, HOLD_CYCLES + 4, 1);
`endif
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         do_request(3'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, HOLD_CYCLES)) : 0,
                    int'($urandom_range(1, 3)));
      end
   endtask

   initial begin
      test_reset();
      test_grant();
      test_lockout();
      test_recovery();
      test_ignored();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
